am386sx_bus_master: RTL

//  CPU-side initiator for the Am386SX local bus (non-pipelined). Turns a simple request/response

---
 rtl/am386sx_bus_master.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/am386sx_bus_master.sv
// Am386SX non-pipelined local-bus initiator: turns a request/response handshake into
// TI/T1/T2/TH bus cycles on CLK2 and grants HOLD with HOLDA between cycles.
module am386sx_bus_master #(
  parameter int PHASE_CLKS = 2,
  parameter int WAIT_MAX   = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [22:0] req_addr,
  input  logic [1:0]  req_be,
  input  logic        req_wr,
  input  logic        req_dc,
  input  logic        req_mio,
  input  logic        req_lock,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_timeout,
  output logic        ads_n,
  output logic [22:0] addr,
  output logic        bhe_n,
  output logic        ble_n,
  output logic        wr,
  output logic        dc,
  output logic        mio,
  output logic        lock_n,
  output logic [15:0] data_out,
  output logic        data_oe,
  output logic        bus_oe,
  input  logic [15:0] data_in,
  input  logic        ready_n,
  input  logic        hold,
  output logic        holda
);

  typedef enum logic [1:0] {TI, T1, T2, TH} state_t;

  localparam int PH_W = (PHASE_CLKS > 1) ? $clog2(PHASE_CLKS) : 1;

  state_t          state;
  logic [PH_W-1:0] ph;
  logic [7:0]      wait_cnt;

  logic last_ph;
  logic wait_expired;
  logic cycle_ok;
  logic cycle_abort;
  logic accept;

  assign last_ph      = (ph == PH_W'(PHASE_CLKS - 1));
  assign wait_expired = (wait_cnt == 8'(WAIT_MAX - 1));
  assign cycle_ok     = (state == T2) && last_ph && !ready_n;
  assign cycle_abort  = (state == T2) && last_ph && ready_n && wait_expired;

  // Accepting in the last T2 clk lets a queued request start T1 with no idle TI in between.
  assign req_ready = !reset && !hold && last_ph && ((state == TI) || cycle_ok);
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= TI;
      ph          <= '0;
      wait_cnt    <= '0;
      ads_n       <= 1'b1;
      addr        <= '0;
      bhe_n       <= 1'b1;
      ble_n       <= 1'b1;
      wr          <= 1'b0;
      dc          <= 1'b0;
      mio         <= 1'b0;
      lock_n      <= 1'b1;
      data_out    <= '0;
      data_oe     <= 1'b0;
      bus_oe      <= 1'b1;
      holda       <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      // NOTE: every register here uses <=, so each branch sees the pre-edge values and the
      // later "accept" block may override the state chosen by the case without ordering hazards.
      rsp_valid   <= 1'b0;
      rsp_timeout <= 1'b0;
      ph          <= last_ph ? '0 : ph + 1'b1;

      unique case (state)
        TI: begin
          if (last_ph && hold) begin
            state  <= TH;
            holda  <= 1'b1;
            bus_oe <= 1'b0;
          end
        end
        T1: begin
          if (ph == '0 && wr) data_oe <= 1'b1;
          if (last_ph) begin
            state <= T2;
            ads_n <= 1'b1;
          end
        end
        T2: begin
          if (cycle_ok || cycle_abort) begin
            state       <= TI;
            rsp_valid   <= 1'b1;
            rsp_timeout <= cycle_abort;
            rsp_rdata   <= (cycle_abort || wr) ? 16'h0000 : data_in;
            data_oe     <= 1'b0;
            lock_n      <= 1'b1;
            bhe_n       <= 1'b1;
            ble_n       <= 1'b1;
            wait_cnt    <= '0;
          end else if (last_ph) begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        TH: begin
          if (last_ph && !hold) begin
            state  <= TI;
            holda  <= 1'b0;
            bus_oe <= 1'b1;
          end
        end
        default: state <= TI;
      endcase

      // An empty byte-enable field is promoted to a full-word access.
      if (accept) begin
        state    <= T1;
        ads_n    <= 1'b0;
        addr     <= req_addr;
        bhe_n    <= (req_be == 2'b00) ? 1'b0 : ~req_be[1];
        ble_n    <= (req_be == 2'b00) ? 1'b0 : ~req_be[0];
        wr       <= req_wr;
        dc       <= req_dc;
        mio      <= req_mio;
        lock_n   <= ~req_lock;
        data_out <= req_wdata;
      end
    end
  end

endmodule
